// File: rtl/digits_to_snum_if.sv
// Committed-value stream from the keypad accumulator to its consumer.
// The master drives the value and out_valid; the slave answers with out_ready.
interface digits_to_snum_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mag;
  logic       out_neg;

  modport master (output out_valid, output out_mag, output out_neg, input out_ready);
  modport slave  (input out_valid, input out_mag, input out_neg, output out_ready);
endinterface

// File: rtl/digits_to_snum.sv
// Keypad digit accumulator: builds a signed decimal entry and hands it off over a valid/ready stream.
// Optional feature: define DIGITS_TO_SNUM_BACKSPACE_EN to make the backspace strobe remove the last digit.
module digits_to_snum #(
  parameter int MAX_DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     digit_valid,
  input  logic [3:0]               digit,
  input  logic                     neg_toggle,
  input  logic                     backspace,
  input  logic                     clear,
  input  logic                     enter,
  digits_to_snum_if.master         out_bus,
  output logic [7:0]               cur_mag,
  output logic                     cur_neg,
  output logic [1:0]               ndigits,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] MAX_ND = MAX_DIGITS[1:0];

  state_t      state, state_nxt;
  logic [7:0]  mag_nxt;
  logic        neg_nxt;
  logic [1:0]  nd_nxt;
  logic        ovf_nxt;
  logic [7:0]  out_mag_q, out_mag_nxt;
  logic        out_neg_q, out_neg_nxt;
  logic [11:0] prod;

`ifndef DIGITS_TO_SNUM_BACKSPACE_EN
  logic unused_backspace;
  assign unused_backspace = backspace;
`endif

  // HOLD is exactly the state in which a committed value is offered.
  assign out_bus.out_valid = (state == S_HOLD);
  assign out_bus.out_mag   = out_mag_q;
  assign out_bus.out_neg   = out_neg_q;

  // Widened so values like 25*10+6 are seen as out of range rather than wrapping.
  assign prod = {4'd0, cur_mag} * 12'd10 + {8'd0, digit};

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    mag_nxt     = cur_mag;
    neg_nxt     = cur_neg;
    nd_nxt      = ndigits;
    ovf_nxt     = ovf;
    out_mag_nxt = out_mag_q;
    out_neg_nxt = out_neg_q;

    if (clear || (state == S_HOLD && out_bus.out_ready)) begin
      state_nxt = S_EMPTY;
      mag_nxt   = 8'd0;
      neg_nxt   = 1'b0;
      nd_nxt    = 2'd0;
      ovf_nxt   = 1'b0;
    end else if (state == S_HOLD) begin
      state_nxt = S_HOLD;
    end else if (enter) begin
      if (state == S_ENTRY) begin
        out_mag_nxt = cur_mag;
        out_neg_nxt = cur_neg && (cur_mag != 8'd0);
        state_nxt   = S_HOLD;
      end
`ifdef DIGITS_TO_SNUM_BACKSPACE_EN
    end else if (backspace) begin
      if (state == S_ENTRY) begin
        mag_nxt = cur_mag / 8'd10;
        nd_nxt  = ndigits - 2'd1;
        if (ndigits == 2'd1) state_nxt = S_EMPTY;
      end
`endif
    end else if (neg_toggle) begin
      neg_nxt = ~cur_neg;
    end else if (digit_valid && digit <= 4'd9) begin
      if (ndigits == MAX_ND || prod > 12'd255) begin
        ovf_nxt = 1'b1;
      end else begin
        mag_nxt   = prod[7:0];
        nd_nxt    = ndigits + 2'd1;
        state_nxt = S_ENTRY;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      cur_mag   <= 8'd0;
      cur_neg   <= 1'b0;
      ndigits   <= 2'd0;
      ovf       <= 1'b0;
      out_mag_q <= 8'd0;
      out_neg_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_mag   <= mag_nxt;
      cur_neg   <= neg_nxt;
      ndigits   <= nd_nxt;
      ovf       <= ovf_nxt;
      out_mag_q <= out_mag_nxt;
      out_neg_q <= out_neg_nxt;
    end
  end

endmodule

// File: tb/tb_digits_to_snum.sv
// Directed bench for digits_to_snum: each task drives one scenario and checks hand-computed results.
// Snapshot layout: {out_valid, out_mag, out_neg, cur_mag, cur_neg, ndigits, ovf}.
module tb_digits_to_snum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       neg_toggle = 1'b0;
  logic       backspace = 1'b0;
  logic       clear = 1'b0;
  logic       enter = 1'b0;
  logic [7:0] cur_mag;
  logic       cur_neg;
  logic [1:0] ndigits;
  logic       ovf;

  int passed = 0;
  int total  = 0;

  digits_to_snum_if bus ();

  digits_to_snum #(.MAX_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .neg_toggle(neg_toggle), .backspace(backspace), .clear(clear), .enter(enter),
    .out_bus(bus.master), .cur_mag(cur_mag), .cur_neg(cur_neg), .ndigits(ndigits), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] snap();
    return {bus.out_valid, bus.out_mag, bus.out_neg, cur_mag, cur_neg, ndigits, ovf};
  endfunction

  function automatic logic [21:0] want(input logic ov, input logic [7:0] om, input logic on,
                                       input logic [7:0] cm, input logic cn,
                                       input logic [1:0] nd, input logic of);
    return {ov, om, on, cm, cn, nd, of};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic dv, input logic [3:0] d, input logic nt,
                       input logic bs, input logic clr, input logic ent);
    digit_valid = dv; digit = d; neg_toggle = nt; backspace = bs; clear = clr; enter = ent;
    step();
    digit_valid = 1'b0; digit = 4'd0; neg_toggle = 1'b0; backspace = 1'b0; clear = 1'b0; enter = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    pulse(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    #2;
    total++;
    if (snap() !== 22'd0) $display("FAIL reset_state: got %h want %h", snap(), 22'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (snap() !== 22'd0) $display("FAIL reset_release: got %h want %h", snap(), 22'd0);
    else passed++;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    key(4'd1); key(4'd2); key(4'd7);
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd127, 0, 2'd3, 0))
      $display("FAIL basic_digits: got %h want %h", snap(), want(0, 8'd0, 0, 8'd127, 0, 2'd3, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap() !== want(1, 8'd127, 1, 8'd127, 1, 2'd3, 0))
      $display("FAIL basic_commit: got %h want %h", snap(), want(1, 8'd127, 1, 8'd127, 1, 2'd3, 0));
    else passed++;
    step();
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL basic_handshake: got %h want %h", snap(), want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
  endtask

  task automatic test_overflow();
    key(4'd12);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL ovf_bad_key: got %h want %h", snap(), want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
    key(4'd2); key(4'd5); key(4'd6);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd25, 0, 2'd2, 1))
      $display("FAIL ovf_range: got %h want %h", snap(), want(0, 8'd127, 1, 8'd25, 0, 2'd2, 1));
    else passed++;
    key(4'd5);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd255, 0, 2'd3, 1))
      $display("FAIL ovf_255: got %h want %h", snap(), want(0, 8'd127, 1, 8'd255, 0, 2'd3, 1));
    else passed++;
    key(4'd0);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd255, 0, 2'd3, 1))
      $display("FAIL ovf_max_digits: got %h want %h", snap(), want(0, 8'd127, 1, 8'd255, 0, 2'd3, 1));
    else passed++;
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL ovf_clear: got %h want %h", snap(), want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL enter_in_empty: got %h want %h", snap(), want(0, 8'd127, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
  endtask

  task automatic test_neg_zero();
    bus.out_ready = 1'b0;
    pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    key(4'd0);
    total++;
    if (snap() !== want(0, 8'd127, 1, 8'd0, 1, 2'd1, 0))
      $display("FAIL negz_entry: got %h want %h", snap(), want(0, 8'd127, 1, 8'd0, 1, 2'd1, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap() !== want(1, 8'd0, 0, 8'd0, 1, 2'd1, 0))
      $display("FAIL negz_commit: got %h want %h", snap(), want(1, 8'd0, 0, 8'd0, 1, 2'd1, 0));
    else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd0, 0, 2'd0, 0))
      $display("FAIL negz_release: got %h want %h", snap(), want(0, 8'd0, 0, 8'd0, 0, 2'd0, 0));
    else passed++;
  endtask

  task automatic test_hold();
    key(4'd3); key(4'd4);
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 4'(i + 1), (i == 2), 1'b0, 1'b0, 1'b1);
      total++;
      if (snap() !== want(1, 8'd34, 0, 8'd34, 0, 2'd2, 0))
        $display("FAIL hold_stable_%0d: got %h want %h", i, snap(), want(1, 8'd34, 0, 8'd34, 0, 2'd2, 0));
      else passed++;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (snap() !== want(0, 8'd34, 0, 8'd0, 0, 2'd0, 0))
      $display("FAIL hold_release: got %h want %h", snap(), want(0, 8'd34, 0, 8'd0, 0, 2'd0, 0));
    else passed++;
    key(4'd9);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (snap() !== want(0, 8'd9, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL hold_clear: got %h want %h", snap(), want(0, 8'd9, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
  endtask

  task automatic test_priority();
    key(4'd7);
    pulse(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (snap() !== want(0, 8'd9, 1, 8'd0, 0, 2'd0, 0))
      $display("FAIL prio_clear_digit: got %h want %h", snap(), want(0, 8'd9, 1, 8'd0, 0, 2'd0, 0));
    else passed++;
    key(4'd6);
    pulse(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (snap() !== want(0, 8'd9, 1, 8'd6, 1, 2'd1, 0))
      $display("FAIL prio_neg_digit: got %h want %h", snap(), want(0, 8'd9, 1, 8'd6, 1, 2'd1, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    key(4'd8); key(4'd9);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (snap() !== 22'd0) $display("FAIL reset_mid_async: got %h want %h", snap(), 22'd0);
    else passed++;
    #2;
    rst_n = 1'b1;
    step();
    total++;
    if (snap() !== 22'd0) $display("FAIL reset_mid_after: got %h want %h", snap(), 22'd0);
    else passed++;
  endtask

  task automatic test_backspace();
    pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    key(4'd4); key(4'd2);
    pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef DIGITS_TO_SNUM_BACKSPACE_EN
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd4, 1, 2'd1, 0))
      $display("FAIL bs_one: got %h want %h", snap(), want(0, 8'd0, 0, 8'd4, 1, 2'd1, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd0, 1, 2'd0, 0))
      $display("FAIL bs_to_empty: got %h want %h", snap(), want(0, 8'd0, 0, 8'd0, 1, 2'd0, 0));
    else passed++;
`else
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd42, 1, 2'd2, 0))
      $display("FAIL bs_ignored: got %h want %h", snap(), want(0, 8'd0, 0, 8'd42, 1, 2'd2, 0));
    else passed++;
    pulse(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (snap() !== want(0, 8'd0, 0, 8'd42, 0, 2'd2, 0))
      $display("FAIL bs_passthrough: got %h want %h", snap(), want(0, 8'd0, 0, 8'd42, 0, 2'd2, 0));
    else passed++;
`endif
    pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_neg_zero();
    test_hold();
    test_priority();
    test_reset_mid();
    test_backspace();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/digits_to_snum.md
DIGITS_TO_SNUM -- requirements
Module: digits_to_snum

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, meaning the maximum number of decimal digits accepted per entry (1..3).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port digit_valid, input, 1, a one-cycle strobe that presents a decimal key.
REQ-005 SHALL have port digit, input, 4, the key value 0..9; values 10..15 are ignored.
REQ-006 SHALL have port neg_toggle, input, 1, a strobe that toggles the entry sign.
REQ-007 SHALL have port backspace, input, 1, a strobe that removes the last digit (see Configuration).
REQ-008 SHALL have port clear, input, 1, a strobe that discards the current entry.
REQ-009 SHALL have port enter, input, 1, a strobe that commits the current entry.
REQ-010 SHALL have port out_ready, input, 1, the consumer's acceptance of the committed value.
REQ-011 SHALL have port out_valid, output, 1, asserted while a committed value is held.
REQ-012 SHALL have port out_mag, output, 8, the committed unsigned magnitude.
REQ-013 SHALL have port out_neg, output, 1, the committed sign (1 = negative).
REQ-014 SHALL have port cur_mag, output, 8, the live entry magnitude, for display chaining.
REQ-015 SHALL have port cur_neg, output, 1, the live entry sign.
REQ-016 SHALL have port ndigits, output, 2, the count of digits currently entered.
REQ-017 SHALL have port ovf, output, 1, a sticky flag: digit rejected because of range.

Function
REQ-018 SHALL implement states EMPTY (ndigits=0), ENTRY (ndigits>0) and HOLD (out_valid=1).
REQ-019 SHALL process at most one event per cycle; priority is clear > enter > backspace > neg_toggle > digit_valid, and lower-priority strobes in the same cycle are dropped.
REQ-020 SHALL, on an accepted digit in EMPTY/ENTRY, register cur_mag <= cur_mag*10 + digit and ndigits+1, effective on the next edge; the arithmetic is evaluated at 12 bits internally.
REQ-021 SHALL reject a digit if ndigits = MAX_DIGITS or if the 12-bit result exceeds 255; on rejection, state and value are unchanged and ovf is set.
REQ-022 SHALL accept a leading 0 digit (increments ndigits, magnitude stays 0).
REQ-023 SHALL, on neg_toggle in EMPTY/ENTRY, invert cur_neg; this is allowed in EMPTY.
REQ-024 SHALL, on enter in ENTRY, copy cur_mag to out_mag, go to HOLD, and assert out_valid on the next cycle.
REQ-025 SHALL force out_neg to 0 when the committed magnitude is 0 (no negative zero); otherwise out_neg = cur_neg.
REQ-026 SHALL ignore enter in EMPTY.
REQ-027 SHALL, in HOLD, keep out_valid, out_mag and out_neg stable until out_valid & out_ready are both sampled high.
REQ-028 SHALL, on that out_valid & out_ready handshake, deassert out_valid on the next cycle, zero cur_mag, cur_neg, ndigits and ovf, and go to EMPTY.
REQ-029 SHALL, in HOLD, ignore digit, neg_toggle, backspace and enter; clear in HOLD drops the held value (out_valid <= 0) and goes to EMPTY.
REQ-030 SHALL, on clear in any state, zero cur_mag, cur_neg, ndigits and ovf.
REQ-031 SHALL clear ovf only on clear, on the handshake, or on reset.
REQ-032 SHALL hold out_mag and out_neg at their last committed values when out_valid=0.

Reset
REQ-033 SHALL, on rst_n low, immediately set state EMPTY and all outputs to 0 (out_valid, out_mag, out_neg, cur_mag, cur_neg, ndigits, ovf), independent of clk.
REQ-034 SHALL discard any entry or held value when reset is asserted mid-operation; no partial commit occurs.

Configuration
REQ-035 SHALL, with DIGITS_TO_SNUM_BACKSPACE_EN defined and backspace asserted in ENTRY, set cur_mag <= cur_mag/10 and decrement ndigits; reaching 0 digits returns to EMPTY with cur_neg kept and ovf unchanged.
REQ-036 SHALL, with DIGITS_TO_SNUM_BACKSPACE_EN defined, ignore backspace in EMPTY and HOLD.
REQ-037 SHALL, without DIGITS_TO_SNUM_BACKSPACE_EN, keep the backspace port but ignore it entirely, so it never consumes the priority slot and lower-priority events proceed.

Verification
REQ-038 SHALL cover: digits 1,2,7, neg_toggle, enter, out_ready high -> out_valid one cycle after enter with out_mag=127, out_neg=1; EMPTY after the handshake.
REQ-039 SHALL cover: digits 2,5,6 -> ovf=1, cur_mag=25, ndigits=2; then digit 5 -> cur_mag=255; a further digit is rejected (MAX_DIGITS).
REQ-040 SHALL cover: neg_toggle, digit 0, enter -> out_mag=0, out_neg=0.
REQ-041 SHALL cover: a committed value with out_ready low for 5 cycles plus digit strobes -> outputs stable and digits ignored; out_ready high -> release.
REQ-042 SHALL cover: clear and digit 4 in the same cycle -> cur_mag=0, ndigits=0; rst_n low mid-entry between edges -> all outputs 0 immediately.
REQ-043 SHALL cover: with the macro, digits 4,2 then backspace -> cur_mag=4, ndigits=1; without the macro -> unchanged at 42.
